// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the RX echo FIFO and the message generator:
// round-robin grant, one frame per grant, with a watchdog on the tx_done pulse.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYC = 200000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_fifo_empty,
  input  logic [7:0]       i_fifo_rdata,
  output logic             o_fifo_pop,
  input  logic             i_msg_valid,
  input  logic [7:0]       i_msg_data,
  output logic             o_msg_ready,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_din,
  input  logic             i_tx_done,
  output logic [1:0]       o_grant,
  output logic             o_busy,
  output logic             o_timeout_err,
  input  logic             i_clr_err,
  output logic [CNT_W-1:0] o_echo_cnt,
  output logic [CNT_W-1:0] o_msg_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t         state;
  logic           last_grant_msg;
  logic [WD_W-1:0] wd_cnt;
  logic           req_e;
  logic           req_m;
  logic           grant_e;
  logic           grant_m;

  // Handshake: the echo byte is consumed on any cycle with o_fifo_pop = 1 (FWFT head),
  // the message byte on i_msg_valid & o_msg_ready; both only in IDLE, never together,
  // and forced low while reset is held.
  always_comb begin
    req_e   = i_en & ~i_fifo_empty;
    req_m   = i_en & i_msg_valid;
    grant_e = 1'b0;
    grant_m = 1'b0;
    if (rst && state == ST_IDLE) begin
      if (req_e && req_m) begin
        grant_e = last_grant_msg;
        grant_m = ~last_grant_msg;
      end else begin
        grant_e = req_e;
        grant_m = req_m;
      end
    end
  end

  assign o_fifo_pop  = grant_e;
  assign o_msg_ready = grant_m;
  assign dbg_state   = state;

  // The watchdog runs from the start cycle, so TIMEOUT_CYC counts cycles from the
  // start pulse; a done arriving on the last allowed cycle still completes the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      last_grant_msg <= 1'b1;
      wd_cnt         <= '0;
      o_tx_start     <= 1'b0;
      o_tx_din       <= 8'h00;
      o_grant        <= 2'b00;
      o_busy         <= 1'b0;
      o_timeout_err  <= 1'b0;
      o_echo_cnt     <= '0;
      o_msg_cnt      <= '0;
    end else begin
      if (i_clr_err) o_timeout_err <= 1'b0;
      o_tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_e || grant_m) begin
            o_tx_din       <= grant_e ? i_fifo_rdata : i_msg_data;
            last_grant_msg <= grant_m;
            o_grant        <= {grant_m, grant_e};
            wd_cnt         <= '0;
            o_tx_start     <= 1'b1;
            o_busy         <= 1'b1;
            state          <= ST_START;
          end
        end
        ST_START: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          state  <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_tx_done) begin
            if (o_grant[0]) o_echo_cnt <= o_echo_cnt + CNT_W'(1);
            else            o_msg_cnt  <= o_msg_cnt + CNT_W'(1);
            o_grant <= 2'b00;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end else if (wd_cnt == WD_LAST) begin
            o_timeout_err <= 1'b1;
            o_grant       <= 2'b00;
            o_busy        <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: begin
          o_grant <= 2'b00;
          o_busy  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART_tx transmitter between two byte sources.
- Echo path: the RX FIFO, first-word fall-through.
- Message path: local status/message generator, valid/ready handshake.
- Round-robin arbitration; sequences one transmitter frame per grant (start pulse, hold din, wait for tx_done) with a watchdog on tx_done.
- Sits between the RX FIFO / message generator and UART_tx in the UART_FIFO top.

Parameters:
TIMEOUT_CYC, 200000, clk cycles allowed from tx start to tx_done before a timeout is declared (≥ 1 frame at 9600 baud, 100 MHz)
CNT_W, 16, width of per-source frame counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
i_en  in  1  1 = new grants allowed; 0 = finish current frame, then hold idle
i_fifo_empty  in  1  RX FIFO empty flag
i_fifo_rdata  in  8  RX FIFO head byte, valid whenever i_fifo_empty = 0
o_fifo_pop  out  1  one-cycle pop strobe to RX FIFO
i_msg_valid  in  1  message byte valid
i_msg_data  in  8  message byte
o_msg_ready  out  1  message byte accepted when i_msg_valid & o_msg_ready
o_tx_start  out  1  one-cycle start pulse to UART_tx
o_tx_din  out  8  byte to UART_tx, stable from start until tx_done
i_tx_done  in  1  UART_tx frame-complete pulse
o_grant  out  2  one-hot current owner: [0] echo, [1] msg, 00 when idle
o_busy  out  1  1 in any state other than IDLE
o_timeout_err  out  1  sticky watchdog error flag
i_clr_err  in  1  clears o_timeout_err
o_echo_cnt  out  CNT_W  completed echo frames
o_msg_cnt  out  CNT_W  completed message frames

Behaviour:
- Reset (rst = 0, asynchronous):
  - State = IDLE; all outputs 0; o_tx_din = 8'h00; counters 0.
  - last_grant = msg, so echo wins the first contention.
- States:
  - IDLE: evaluate requests. req_e = ~i_fifo_empty; req_m = i_msg_valid; both are qualified by i_en.
    - Only one request: grant it.
    - Both requests: grant the source ≠ last_grant.
    - No request: stay in IDLE.
  - Grant cycle in IDLE (combinational, same cycle):
    - o_fifo_pop = 1 for echo, or o_msg_ready = 1 for msg.
    - On that edge: o_tx_din ← selected byte; last_grant and o_grant updated; watchdog cleared; next state = START.
  - START: o_tx_start = 1 for exactly this cycle → WAIT_DONE.
  - WAIT_DONE: watchdog counts every cycle.
    - i_tx_done = 1: increment the granted source's counter → IDLE.
    - Watchdog reaches TIMEOUT_CYC-1 without i_tx_done: set o_timeout_err, no count → IDLE.
- Latency:
  - Request visible in IDLE at cycle N → pop/ready at N, o_tx_start at N+1.
  - Back-to-back: next grant no earlier than the cycle after the tx_done cycle, so at most one pop/ready per frame.
- o_grant holds its one-hot value from START through WAIT_DONE; it is 00 in IDLE outside the grant edge.
- o_tx_din is unchanged until the next grant.
- Pop and ready are never asserted together, and never outside IDLE.
- Boundary conditions:
  - i_tx_done and timeout in the same cycle: done wins (counted, no error).
  - i_tx_done while in IDLE or START: ignored.
  - i_en deasserted mid-frame: current frame completes and is counted; no new grant.
  - i_fifo_empty rising in the same cycle as the grant is impossible by FWFT contract; the grant uses the sampled value.
  - i_clr_err and a timeout in the same cycle: set wins.
  - Counters wrap from 2^CNT_W-1 to 0.
  - Reset mid-frame: immediate return to reset values; the in-flight byte is dropped and not re-popped.

Test Plan:
1. Reset: rst = 0 for 3 cycles, then release → all outputs 0; o_grant = 00; o_busy = 0.
2. Single echo: FIFO holds 8'h30, UART_tx model returns tx_done 104170 cycles after start → o_fifo_pop one cycle; o_tx_start next cycle with o_tx_din = 8'h30; o_echo_cnt = 1; o_busy falls the cycle after done.
3. Contention: FIFO holds 8'hA1, 8'hA2; msg_valid held with 8'h55 → transmit order A1, 55, A2; o_echo_cnt = 2, o_msg_cnt = 1; exactly one pop or ready per frame.
4. Timeout: TIMEOUT_CYC = 50, tx_done never returned → o_timeout_err = 1 at cycle 50 after start, counters unchanged; i_clr_err pulse → 0. Variant with done at cycle 49 and timeout coinciding → counted, no error.
5. Enable: i_en = 0 asserted during WAIT_DONE with FIFO non-empty → current frame completes; no further pop until i_en = 1, then the next byte is sent.
6. Reset mid-frame: rst = 0 in WAIT_DONE → outputs cleared asynchronously; after release the FIFO head is granted fresh and o_echo_cnt = 0.
